// File: rtl/seg7_scan.sv
// Multiplexed 7-segment hex display driver: scans DIGITS digits on rising edges of tick,
// inserts an all-off dead time between digits and snapshots the display data once per scan.
module seg7_scan #(
    parameter int DIGITS      = 4,
    parameter int DEAD_CYCLES = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_LZ    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  scan_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [GW-1:0]     GAP_LAST = GW'(DEAD_CYCLES - 1);
    localparam logic              POL      = (ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{POL}};
    localparam logic [6:0]        SEG_OFF  = {7{POL}};

    typedef enum logic {ST_GAP = 1'b0, ST_ACTIVE = 1'b1} state_t;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    function automatic logic lz_blank(input logic [4*DIGITS-1:0] d, input logic [IW-1:0] i);
        logic nz;
        nz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            nz = nz | ((k >= int'(i)) && (d[4*k +: 4] != 4'h0));
        end
        return (i != {IW{1'b0}}) && !nz;
    endfunction

    state_t                state_r, state_s;
    logic                  tick_q_r;
    logic [IW-1:0]         idx_r, idx_s;
    logic [GW-1:0]         gap_cnt_r, gap_cnt_s;
    logic [4*DIGITS-1:0]   shadow_r, shadow_s;
    logic [DIGITS-1:0]     shadow_dp_r, shadow_dp_s;
    logic                  scan_start_r, scan_start_s;
    logic [DIGITS-1:0]     an_r, an_s;
    logic [6:0]            seg_r, seg_s;
    logic                  dp_r, dp_s;

    logic                  rise_s, load_s, blank_s;
    logic [4*DIGITS-1:0]   src_data_s;
    logic [DIGITS-1:0]     src_dp_s;
    logic [3:0]            nib_s;
    logic [DIGITS-1:0]     digit_an_s;
    logic [6:0]            digit_seg_s;
    logic                  digit_dp_s;

    // Digit image for idx; uses the incoming data when the shadow is being loaded this cycle.
    always_comb begin
        rise_s      = tick & ~tick_q_r;
        load_s      = (state_r == ST_GAP) && (gap_cnt_r == {GW{1'b0}}) && (idx_r == {IW{1'b0}});
        src_data_s  = load_s ? data  : shadow_r;
        src_dp_s    = load_s ? dp_in : shadow_dp_r;
        nib_s       = src_data_s[{idx_r, 2'b00} +: 4];
        blank_s     = (BLANK_LZ != 0) && lz_blank(src_data_s, idx_r);
        digit_an_s  = blank_s ? {DIGITS{1'b0}} : (DIGITS'(1'b1) << idx_r);
        digit_seg_s = blank_s ? 7'h00 : hex_decode(nib_s);
        digit_dp_s  = blank_s ? 1'b0  : src_dp_s[idx_r];
    end

    // Scan FSM next-state and registered-output next values.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        gap_cnt_s    = gap_cnt_r;
        shadow_s     = shadow_r;
        shadow_dp_s  = shadow_dp_r;
        scan_start_s = 1'b0;
        an_s         = an_r;
        seg_s        = seg_r;
        dp_s         = dp_r;
        case (state_r)
            ST_GAP: begin
                an_s  = AN_OFF;
                seg_s = SEG_OFF;
                dp_s  = POL;
                if (load_s) begin
                    shadow_s     = data;
                    shadow_dp_s  = dp_in;
                    scan_start_s = 1'b1;
                end else begin
                    scan_start_s = 1'b0;
                end
                if (gap_cnt_r == GAP_LAST) begin
                    state_s   = ST_ACTIVE;
                    gap_cnt_s = {GW{1'b0}};
                    an_s      = digit_an_s ^ AN_OFF;
                    seg_s     = digit_seg_s ^ SEG_OFF;
                    dp_s      = digit_dp_s ^ POL;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1'b1);
                end
            end
            ST_ACTIVE: begin
                if (rise_s) begin
                    state_s = ST_GAP;
                    idx_s   = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1'b1);
                    an_s    = AN_OFF;
                    seg_s   = SEG_OFF;
                    dp_s    = POL;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s   = ST_GAP;
                idx_s     = {IW{1'b0}};
                gap_cnt_s = {GW{1'b0}};
                an_s      = AN_OFF;
                seg_s     = SEG_OFF;
                dp_s      = POL;
            end
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q_r     <= 1'b0;
            state_r      <= ST_GAP;
            idx_r        <= {IW{1'b0}};
            gap_cnt_r    <= {GW{1'b0}};
            shadow_r     <= {(4*DIGITS){1'b0}};
            shadow_dp_r  <= {DIGITS{1'b0}};
            scan_start_r <= 1'b0;
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            dp_r         <= POL;
        end else begin
            tick_q_r     <= tick;
            state_r      <= state_s;
            idx_r        <= idx_s;
            gap_cnt_r    <= gap_cnt_s;
            shadow_r     <= shadow_s;
            shadow_dp_r  <= shadow_dp_s;
            scan_start_r <= scan_start_s;
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign scan_start = scan_start_r;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed 7-segment hex display driver; sits directly downstream of clkdiv.
- Consumes clkdiv's divided square wave `out` as its scan-rate input `tick`, in the same `clk` domain.
- Each rising edge of `tick` advances to the next digit. A dead-time gap between digits suppresses ghosting.
- Displayed data is snapshotted once per full scan, so the display never shows a mix of old and new values.

Parameters:
- DIGITS, 4, number of digits (1..8).
- DEAD_CYCLES, 4, clk cycles with all anodes off between digits (>=1).
- ACTIVE_LOW, 1, 1: an/seg/dp active low; 0: active high.
- BLANK_LZ, 0, 1: blank leading-zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  scan-rate square wave from clkdiv; synchronous to clk; only rising edges are used
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]
- dp_in  in  DIGITS  decimal point request per digit
- an  out  DIGITS  digit enables (one-hot when active)
- seg  out  7  segments, bit0=a … bit6=g
- dp  out  1  decimal point
- scan_start  out  1  one-cycle pulse when the shadow is loaded

Behaviour:
- Reset (async, rst_n=0):
  - tick_q=0, state=GAP, idx=0, gap_cnt=0, shadow data/dp=0, scan_start=0.
  - an/seg/dp all "off": all ones if ACTIVE_LOW, else all zeros.
- Edge detect: rise = tick & ~tick_q; tick_q <= tick every cycle.
- All outputs are registered. Outputs change only on clk edges (or async reset).
- State GAP:
  - an, seg, dp off.
  - If gap_cnt==0 and idx==0: load shadow <= data, shadow_dp <= dp_in, and pulse scan_start in the following cycle. This also fires in the first cycle after reset release.
  - gap_cnt increments each cycle.
  - When gap_cnt==DEAD_CYCLES-1: state <= ACTIVE and gap_cnt <= 0. an, seg and dp for digit idx become valid at that same edge.
  - A rise during GAP is ignored: no queueing, no idx change.
- State ACTIVE:
  - an = one-hot bit idx.
  - seg = hexdec(shadow nibble idx).
  - dp = shadow_dp[idx].
  - On rise: state <= GAP, idx <= (idx==DIGITS-1) ? 0 : idx+1, and an/seg/dp go off at that same edge. Latency from the first clk edge sampling tick=1 to anodes off is 1 edge.
- Hex decode, active-high, bits g..a:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - ACTIVE_LOW inverts seg, an and dp.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit idx>0 is blanked when shadow nibbles idx..DIGITS-1 are all zero.
  - A blanked digit keeps its anode off and seg/dp off for its ACTIVE period; timing is unchanged.
- Data changes mid-scan have no visible effect until the next idx==0 GAP load.
- Simultaneous events:
  - rise on the same cycle as the GAP→ACTIVE transition is ignored (still in GAP).
  - rise on the first ACTIVE cycle ends that digit immediately after one cycle.
- Reset mid-operation: outputs go off immediately (async). Scanning restarts from idx=0 with a fresh load.
- tick stuck at a constant level: the current digit stays ACTIVE indefinitely.

Test Plan:
- Reset: hold rst_n=0 with tick toggling → an=4'hF, seg=7'h7F, dp=1, scan_start=0. Release rst_n → scan_start pulses once, 2 cycles later.
- Normal scan: DIGITS=4, ACTIVE_LOW=1, data=16'h1234, dp_in=0, tick period 40 clk.
  - an sequence 1110/1101/1011/0111 with seg 7'h19(4)/7'h30(3)/7'h24(2)/7'h79(1).
  - Each digit is preceded by exactly 4 cycles of an=4'hF.
  - an goes off 1 edge after tick rises.
- Tearing: data=16'h1234, then switch to 16'hABCD while idx=2 → digits 2 and 3 still show 2 and 1. The next scan shows D, C, b, A (seg 7'h21, 7'h46, 7'h03, 7'h08). scan_start pulses once per scan.
- Blanking: BLANK_LZ=1, data=16'h0050, dp_in=4'b0010.
  - Digits 3 and 2: an stays 4'hF for their slots.
  - Digit 1: seg 7'h12, dp=0.
  - Digit 0: seg 7'h40, dp=1.
- Fast tick: tick period 2 clk, DEAD_CYCLES=4 → rises during GAP are ignored. Every digit is active for ≥1 cycle and idx advances by exactly 1 per ACTIVE period (never skips).
- Reset mid-ACTIVE at idx=2: assert rst_n=0 asynchronously → an=4'hF before the next clk edge. After release, the scan restarts at digit 0 with the current data.
